// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: out = in0 - in1, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop process the operands over WIDTH cycles.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       request; accepted only in IDLE or DONE
//   in0, in1    minuend / subtrahend, captured on the accept edge
//   busy        high while the operation runs
//   done        one-cycle pulse when out/bout/zero carry a new result
//   out         difference modulo 2^WIDTH
//   bout        final borrow (in0 < in1, unsigned)
//   zero        high when out == 0
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   a, a_d;
    logic [WIDTH-1:0]   b, b_d;
    logic [WIDTH-1:0]   res, res_d;
    logic               brw, brw_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]   out_d;
    logic               bout_d, zero_d, busy_d, done_d;

    // Full-subtractor cell on the current LSBs
    logic               diff_bit;
    logic               brw_next;
    logic [WIDTH-1:0]   res_shift;

    always_comb begin
        diff_bit  = a[0] ^ b[0] ^ brw;
        brw_next  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & brw);
        res_shift = {diff_bit, res[WIDTH-1:1]};
    end

    // State register and all datapath/output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            bout  <= 1'b0;
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            a     <= a_d;
            b     <= b_d;
            res   <= res_d;
            brw   <= brw_d;
            cnt   <= cnt_d;
            out   <= out_d;
            bout  <= bout_d;
            zero  <= zero_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d = state;
        a_d     = a;
        b_d     = b;
        res_d   = res;
        brw_d   = brw;
        cnt_d   = cnt;
        out_d   = out;
        bout_d  = bout;
        zero_d  = zero;

        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = in0;
                    b_d     = in1;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a >> 1;
                b_d   = b >> 1;
                res_d = res_shift;
                brw_d = brw_next;
                cnt_d = cnt + CNT_W'(1);
                // Last bit processed this cycle: publish the result
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    out_d   = res_shift;
                    bout_d  = brw_next;
                    zero_d  = (res_shift == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the upcoming state
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] in0, in1;
    logic       busy, done, bout, zero;
    logic [7:0] out;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in0   (in0),
        .in1   (in1),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .bout  (bout),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, scramble the inputs after the accept edge, wait for done
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] eo, input logic eb, input logic ez,
                          input string tag);
        int n;
        in0 = x; in1 = y; start = 1'b1;
        tick();
        start = 1'b0; in0 = ~x; in1 = x ^ y;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_out"}, 32'(out), 32'(eo));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0; start = 1'b0; in0 = '0; in1 = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out",  32'(out),  32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        tick();

        run_op(8'h05, 8'h05, 8'h00, 1'b0, 1'b1, "eq");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "neg");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "zero_minus_one");
        run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, "ff_minus_one");
        run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, "80_minus_7f");
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "00_minus_ff");

        // start re-pulsed mid-run is ignored; out holds previous result meanwhile
        in0 = 8'h10; in1 = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        in0 = 8'h00; in1 = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_hold_out", 32'(out), 32'h01);
        for (int i = 0; i < 4; i++) tick();
        chk("ign_not_done_yet", 32'(done), 32'd0);
        tick();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_busy_off", 32'(busy), 32'd0);
        chk("ign_out", 32'(out), 32'h0F);
        chk("ign_bout", 32'(bout), 32'd0);
        tick();
        chk("ign_no_second", 32'(done), 32'd0);
        chk("ign_idle", 32'(busy), 32'd0);

        // Reset mid-run abandons the operation
        in0 = 8'h09; in1 = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_out",  32'(out),  32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd1);
        #3;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("mid_rst_quiet", 32'(seen_done), 32'd0);

        // Back-to-back: start held across DONE, no IDLE cycle in between
        in0 = 8'h40; in1 = 8'h41; start = 1'b1;
        tick();
        in0 = 8'h22; in1 = 8'h22;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_pre_done", 32'(done), 32'd0);
        tick();
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_out1",  32'(out),  32'hFF);
        chk("b2b_bout1", 32'(bout), 32'd1);
        tick();
        start = 1'b0;
        chk("b2b_busy2", 32'(busy), 32'd1);
        chk("b2b_nodone", 32'(done), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_hold_out", 32'(out), 32'hFF);
        chk("b2b_pre_done2", 32'(done), 32'd0);
        tick();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_out2",  32'(out),  32'h00);
        chk("b2b_zero2", 32'(zero), 32'd1);
        chk("b2b_bout2", 32'(bout), 32'd0);
        tick();
        chk("b2b_end", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
